// File: rtl/aes_decrypt_iterative_checksum.sv
// Iterative AES inverse cipher, one round per clock, with valid/ready handshakes and a
// 32-bit XOR fold of every intermediate round state for fault/trace checking.
module aes_decrypt_iterative_checksum #(
    parameter int unsigned N  = 128,
    parameter int unsigned Nr = 10,
    parameter int unsigned Nk = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic [31:0]  state_checksum
);
    localparam int unsigned RW = $clog2(Nr + 1);
    localparam int unsigned NW = 4 * (Nr + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

    state_e         state_q, state_d;
    logic [127:0]   ct_q, st_q;
    logic [N-1:0]   key_q;
    logic [31:0]    chk_q;
    logic [RW-1:0]  rnd_q, rk_idx;
    logic [31:0]    w [NW];
    logic [31:0]    kx_t;
    logic [7:0]     kx_rcon;
    logic [127:0]   rk [Nr+1];
    logic [127:0]   rk_sel, load_st, last_st, mid_st;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, b;
        r = 8'h01;
        b = a;
        for (int i = 1; i < 8; i++) begin
            b = gmul(b, b);
            r = gmul(r, b);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Byte k sits at bits [127-8k -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [31:0] fold(input logic [127:0] s);
        return s[127:96] ^ s[95:64] ^ s[63:32] ^ s[31:0];
    endfunction

    // Full key schedule, combinational from the latched key; stable for the whole block.
    always_comb begin
        kx_t    = '0;
        kx_rcon = 8'h01;
        for (int i = 0; i < int'(Nk); i++) w[i] = key_q[N-1-32*i -: 32];
        for (int i = int'(Nk); i < int'(NW); i++) begin
            kx_t = w[i-1];
            if (i % Nk == 0) begin
                kx_t    = sub_word({kx_t[23:0], kx_t[31:24]}) ^ {kx_rcon, 24'h000000};
                kx_rcon = xtime(kx_rcon);
            end else if (Nk > 6 && i % Nk == 4) begin
                kx_t = sub_word(kx_t);
            end
            w[i] = w[i-Nk] ^ kx_t;
        end
        for (int i = 0; i <= int'(Nr); i++) rk[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    end

    // rnd_q is 0 in LOAD, so the same select yields rk[Nr] there and rk[0] on the last round.
    always_comb begin
        rk_idx  = RW'(Nr) - rnd_q;
        rk_sel  = rk[rk_idx];
        load_st = ct_q ^ rk_sel;
        last_st = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel;
        mid_st  = inv_mix_columns(last_st);
    end

    assign in_ready = (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StLoad;
            StLoad:  state_d = StRound;
            StRound: if (rnd_q == RW'(Nr)) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_q           <= '0;
            key_q          <= '0;
            st_q           <= '0;
            chk_q          <= '0;
            rnd_q          <= '0;
            out            <= '0;
            state_checksum <= '0;
            out_valid      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ct_q  <= in;
                        key_q <= key;
                        rnd_q <= '0;
                    end
                end
                StLoad: begin
                    st_q  <= load_st;
                    chk_q <= fold(load_st);
                    rnd_q <= RW'(1);
                end
                StRound: begin
                    if (rnd_q == RW'(Nr)) begin
                        out            <= last_st;
                        state_checksum <= chk_q ^ fold(last_st);
                        out_valid      <= 1'b1;
                    end else begin
                        st_q  <= mid_st;
                        chk_q <= chk_q ^ fold(mid_st);
                        rnd_q <= rnd_q + RW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
